// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types for the sequence-detector run controller.
package seq_ctrl_pkg;

    localparam int ST_W = 2;

    // Run controller states; encodings are visible on debug taps, keep fixed.
    typedef enum logic [ST_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config/status/serial-data bundle for seq_detect_ctrl.
// Optional build macro: SEQ_CTRL_IRQ_EN adds irq (status) and irq_clr (control).
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
);
    // Control side, driven by the host
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic [CNT_W-1:0] match_target;
    logic [TMO_W-1:0] timeout;
    logic             din;

    // Status side, driven by the controller
    logic             busy;
    logic             det;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic             timed_out;

`ifdef SEQ_CTRL_IRQ_EN
    logic             irq;
    logic             irq_clr;

    modport master (
        output start, abort, pattern, overlap, match_target, timeout, din, irq_clr,
        input  busy, det, match_cnt, done, timed_out, irq
    );

    modport slave (
        input  start, abort, pattern, overlap, match_target, timeout, din, irq_clr,
        output busy, det, match_cnt, done, timed_out, irq
    );
`else
    modport master (
        output start, abort, pattern, overlap, match_target, timeout, din,
        input  busy, det, match_cnt, done, timed_out
    );

    modport slave (
        input  start, abort, pattern, overlap, match_target, timeout, din,
        output busy, det, match_cnt, done, timed_out
    );
`endif

endinterface

// File: rtl/seq_detect_ctrl_core.sv
// Moore pattern detector: shift history, saturating fill count and a
// registered match flag. Oldest history bit sits in the MSB.
module pattern_moore_core #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active low
    input  logic             clr,      // synchronous clear, wins over en
    input  logic             en,       // shift din in this edge
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             det
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              det_q, det_d;

    logic [PAT_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_inc;
    logic [PAT_W-1:0]  bit_eq;
    logic              hit;

    assign shifted  = {hist_q[PAT_W-2:0], din};
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    // Per-bit equality of the post-shift history against the pattern
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = ~(shifted[gi] ^ pattern[gi]);
        end
    endgenerate

    // A match needs a full window of valid bits, not reset zeros
    assign hit = (&bit_eq) && (fill_inc == FILL_FULL);

    // Next history/fill/det: clear, shift, and restart the window on a
    // non-overlapping match
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = shifted;
            fill_d = fill_inc;
            if (hit) begin
                det_d = 1'b1;
                if (!overlap) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
        end
    end

    // Detector state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    assign det = det_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable-pattern Moore sequence detector.
// Latches pattern and run settings on start, feeds din to the detector,
// counts matches and ends the run on match target, timeout or abort.
// Optional build macro: SEQ_CTRL_IRQ_EN adds a sticky irq with irq_clr.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input logic           clk,
    input logic           rst,   // asynchronous, active low
    seq_detect_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [TMO_W-1:0] timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timed_out_q, timed_out_d;

    logic             core_clr;
    logic             core_en;
    logic             det_core;
    logic [CNT_W-1:0] cnt_inc;
    logic             match_end;
    logic             tmo_hit;

    assign core_en = (state_q == RUN);
    assign cnt_inc = cnt_q + CNT_W'(1);
    // det is counted the edge after the bit that completed the pattern
    assign match_end = det_core && (cnt_inc == target_q);
    // Fires one edge after the counter reaches the limit, so a det produced
    // by the limit-th sampled bit is still counted and wins the tie
    assign tmo_hit = (timeout_q != '0) && (tmo_q == timeout_q);

    pattern_moore_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (core_clr),
        .en      (core_en),
        .din     (bus.din),
        .pattern (pattern_q),
        .overlap (overlap_q),
        .det     (det_core)
    );

    // Next state, settings latch and counters; abort > target 0 > match > timeout
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        overlap_d   = overlap_q;
        target_d    = target_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        timed_out_d = timed_out_q;
        core_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    pattern_d   = bus.pattern;
                    overlap_d   = bus.overlap;
                    target_d    = bus.match_target;
                    timeout_d   = bus.timeout;
                    cnt_d       = '0;
                    tmo_d       = '0;
                    timed_out_d = 1'b0;
                    core_clr    = 1'b1;
                end
            end
            RUN: begin
                tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
                if (bus.abort) begin
                    // Leave the count as-is; clearing the core also drops det
                    state_d  = IDLE;
                    core_clr = 1'b1;
                end else if (target_q == '0) begin
                    state_d  = DONE;
                    core_clr = 1'b1;
                end else begin
                    if (det_core) begin
                        cnt_d = cnt_inc;
                    end
                    if (match_end) begin
                        state_d  = DONE;
                        core_clr = 1'b1;
                    end else if (tmo_hit) begin
                        state_d     = DONE;
                        timed_out_d = 1'b1;
                        core_clr    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            overlap_q   <= 1'b0;
            target_q    <= '0;
            timeout_q   <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            overlap_q   <= overlap_d;
            target_q    <= target_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.det       = det_core;
    assign bus.match_cnt = cnt_q;
    assign bus.timed_out = timed_out_q;

`ifdef SEQ_CTRL_IRQ_EN
    logic irq_q, irq_d;

    // Sticky interrupt: rises with done (or timed_out), set beats clear
    always_comb begin
        irq_d = irq_q;
        if (bus.irq_clr) begin
            irq_d = 1'b0;
        end
        if (((state_q == RUN) && (state_d == DONE)) || (timed_out_d && !timed_out_q)) begin
            irq_d = 1'b1;
        end
    end

    // Interrupt register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`endif

endmodule
